// File: rtl/and32_arb_pkg.sv
// Shared constants and slot-state encoding for the AND-reduction arbiter.
package and32_arb_pkg;

  localparam int DATA_W          = 32;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/and32_arb_if.sv
// Request/response bundle between the requesters, the arbiter and the result consumer.
interface and32_arb_if
  import and32_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic                      resp_y;

  // Requester/consumer side
  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y
  );

endinterface

// File: rtl/and32_arb_and32.sv
// Combinational 32-input AND reduction shared by all requesters.
module and32 (
  input  logic [31:0] a,
  output logic        y
);

  assign y = &a;

endmodule

// File: rtl/and32_arb.sv
// Round-robin arbiter feeding one shared and32 with a single-entry output slot.
module and32_arb
  import and32_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = 2
) (
  input  logic        clk,
  input  logic        rst_aL,
  and32_arb_if.slave  bus
);

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  slot_state_t        state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      scan;
  logic               found;
  logic               slot_open;
  logic               transfer;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  operand;
  logic               and_y;
  logic [ID_W-1:0]    hold_id;
  logic               hold_y;

  // Find the first valid requester at or above rr_ptr, wrapping around
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    scan   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan >= NUM_REQ_W) begin
        scan = scan - NUM_REQ_W;
      end
      if (!found && bus.req_valid[scan[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = scan[ID_W-1:0];
      end
    end
  end

  assign slot_open = (state == EMPTY) || bus.resp_ready;

  // Grant the winner only when the slot can take a new result and reset is released
  always_comb begin
    grant = '0;
    if (rst_aL && slot_open && found) begin
      grant[win_id] = 1'b1;
    end
  end

  assign transfer = |grant;
  assign operand  = bus.req_data[int'(win_id)*DATA_W +: DATA_W];

  and32 u_and32 (
    .a (operand),
    .y (and_y)
  );

  // Slot occupancy: fill on transfer, empty when drained without a refill
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state <= EMPTY;
    end else if (transfer) begin
      state <= FULL;
    end else if (bus.resp_ready) begin
      state <= EMPTY;
    end
  end

  // Capture the winner's result and advance the round-robin pointer past it
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      rr_ptr  <= '0;
      hold_id <= '0;
      hold_y  <= 1'b0;
    end else if (transfer) begin
      hold_id <= win_id;
      hold_y  <= and_y;
      rr_ptr  <= (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = (state == FULL);
  assign bus.resp_id    = hold_id;
  assign bus.resp_y     = hold_y;

endmodule
